// File: rtl/invader_march_ctrl.sv
// -----------------------------------------------------------------------------
// invader_march_ctrl
// Formation march controller for the invader wave. It counts video frames,
// commits formation steps on the frame tick, marches horizontally, descends
// and reverses at the playfield edges, and reports landing and wave-cleared
// conditions.
//
// Ports
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset
//   FrameTick  in   1   one-cycle pulse per video frame
//   Start      in   1   one-cycle pulse, leaves IDLE and starts marching
//   Restart    in   1   one-cycle pulse, back to IDLE with initial position
//   Pause      in   1   level, freezes frame counting and stepping
//   InvaderOn  in  50   alive mask, bit = row*10 + col, row 0 at top
//   Delay      in   4   frames-per-step modifier (0..15)
//   FormX      out 10   formation origin X
//   FormY      out 10   formation origin Y
//   Dir        out  1   1 = moving right, 0 = moving left
//   StepPulse  out  1   one cycle high after a step is committed
//   Landed     out  1   formation has reached the landing line
//   Cleared    out  1   every invader is destroyed
// -----------------------------------------------------------------------------
module invader_march_ctrl #(
    parameter int unsigned X_INIT     = 64,
    parameter int unsigned Y_INIT     = 48,
    parameter int unsigned STEP_X     = 8,
    parameter int unsigned STEP_Y     = 16,
    parameter int unsigned COL_PITCH  = 32,
    parameter int unsigned ROW_PITCH  = 24,
    parameter int unsigned INV_W      = 24,
    parameter int unsigned INV_H      = 16,
    parameter int unsigned X_MIN      = 16,
    parameter int unsigned X_MAX      = 624,
    parameter int unsigned Y_LAND     = 400,
    parameter int unsigned MIN_FRAMES = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        FrameTick,
    input  logic        Start,
    input  logic        Restart,
    input  logic        Pause,
    input  logic [49:0] InvaderOn,
    input  logic [3:0]  Delay,
    output logic [9:0]  FormX,
    output logic [9:0]  FormY,
    output logic        Dir,
    output logic        StepPulse,
    output logic        Landed,
    output logic        Cleared
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MARCH   = 2'd1,
        S_LANDED  = 2'd2,
        S_CLEARED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  form_x_q, form_x_d;
    logic [9:0]  form_y_q, form_y_d;
    logic        dir_q, dir_d;
    logic        step_pulse_q, step_pulse_d;
    logic        landed_q, landed_d;
    logic        cleared_q, cleared_d;

    logic [9:0]  col_occ_s;
    logic [4:0]  row_occ_s;
    logic [3:0]  lc_s, rc_s;
    logic [2:0]  br_s;
    logic [11:0] right_edge_s, left_edge_s, bottom_edge_s;
    logic        all_dead_s, landing_s, tick_ok_s, step_due_s;
    logic        hit_edge_s, step_commit_s;
    logic [5:0]  period_s, cnt_inc_s;

    // OR the five rows together so each bit says whether a column has any survivor.
    function automatic logic [9:0] col_occupancy(input logic [49:0] mask);
        logic [9:0] occ;
        occ = 10'd0;
        for (int r = 0; r < 5; r++) begin
            occ = occ | mask[r*10 +: 10];
        end
        return occ;
    endfunction

    // One bit per row: does the row contain any survivor.
    function automatic logic [4:0] row_occupancy(input logic [49:0] mask);
        logic [4:0] occ;
        occ = 5'd0;
        for (int r = 0; r < 5; r++) begin
            occ[r] = |mask[r*10 +: 10];
        end
        return occ;
    endfunction

    // Index of the lowest set bit; the descending scan leaves the lowest one last.
    function automatic logic [3:0] lowest_set(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit of a 10-bit vector.
    function automatic logic [3:0] highest_set10(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit of a 5-bit vector (lowest row on screen).
    function automatic logic [2:0] highest_set5(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Occupancy extents, edge/landing arithmetic and step qualification.
    always_comb begin
        col_occ_s     = col_occupancy(InvaderOn);
        row_occ_s     = row_occupancy(InvaderOn);
        lc_s          = lowest_set(col_occ_s);
        rc_s          = highest_set10(col_occ_s);
        br_s          = highest_set5(row_occ_s);
        // 12-bit intermediates so the sums can exceed the 10-bit origin range.
        right_edge_s  = 12'(form_x_q) + 12'(rc_s) * 12'(COL_PITCH) + 12'(INV_W) + 12'(STEP_X);
        left_edge_s   = 12'(form_x_q) + 12'(lc_s) * 12'(COL_PITCH);
        bottom_edge_s = 12'(form_y_q) + 12'(br_s) * 12'(ROW_PITCH) + 12'(INV_H);
        all_dead_s    = (InvaderOn == 50'd0);
        landing_s     = !all_dead_s && (bottom_edge_s >= 12'(Y_LAND));
        tick_ok_s     = FrameTick && !Pause;
        // Period is sampled live; a counter already past a shrunk period steps at once.
        period_s      = 6'(MIN_FRAMES) + 6'(Delay);
        cnt_inc_s     = {1'b0, frame_cnt_q} + 6'd1;
        step_due_s    = (cnt_inc_s >= period_s);
        if (dir_q) begin
            hit_edge_s = (right_edge_s > 12'(X_MAX));
        end else begin
            hit_edge_s = (left_edge_s < 12'(X_MIN + STEP_X));
        end
        // Restart, clear and landing all pre-empt a step in the same cycle.
        step_commit_s = (state_q == S_MARCH) && !Restart && !all_dead_s && !landing_s
                        && tick_ok_s && step_due_s;
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear detection outranks landing detection.
    always_comb begin
        state_d = state_q;
        if (Restart) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_d = S_MARCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MARCH: begin
                    if (all_dead_s) begin
                        state_d = S_CLEARED;
                    end else if (landing_s) begin
                        state_d = S_LANDED;
                    end else begin
                        state_d = S_MARCH;
                    end
                end
                S_LANDED:  state_d = S_LANDED;
                S_CLEARED: state_d = S_CLEARED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values: frame counter, origin, direction, flags.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        form_x_d     = form_x_q;
        form_y_d     = form_y_q;
        dir_d        = dir_q;
        step_pulse_d = step_commit_s;
        landed_d     = (state_d == S_LANDED);
        cleared_d    = (state_d == S_CLEARED);
        if (Restart) begin
            frame_cnt_d = 5'd0;
            form_x_d    = 10'(X_INIT);
            form_y_d    = 10'(Y_INIT);
            dir_d       = 1'b1;
        end else if ((state_q == S_IDLE) && Start) begin
            frame_cnt_d = 5'd0;
        end else if (step_commit_s) begin
            frame_cnt_d = 5'd0;
            if (hit_edge_s) begin
                // Edge reached: drop a row and turn around without moving sideways.
                form_y_d = form_y_q + 10'(STEP_Y);
                dir_d    = !dir_q;
            end else if (dir_q) begin
                form_x_d = form_x_q + 10'(STEP_X);
            end else begin
                form_x_d = form_x_q - 10'(STEP_X);
            end
        end else if ((state_q == S_MARCH) && tick_ok_s && !all_dead_s && !landing_s) begin
            frame_cnt_d = cnt_inc_s[4:0];
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_q  <= 5'd0;
            form_x_q     <= 10'(X_INIT);
            form_y_q     <= 10'(Y_INIT);
            dir_q        <= 1'b1;
            step_pulse_q <= 1'b0;
            landed_q     <= 1'b0;
            cleared_q    <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            form_x_q     <= form_x_d;
            form_y_q     <= form_y_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            landed_q     <= landed_d;
            cleared_q    <= cleared_d;
        end
    end

    assign FormX     = form_x_q;
    assign FormY     = form_y_q;
    assign Dir       = dir_q;
    assign StepPulse = step_pulse_q;
    assign Landed    = landed_q;
    assign Cleared   = cleared_q;

endmodule

// File: doc/invader_march_ctrl.md
Name: invader_march_ctrl

Overview:
- Downstream consumer of the alive-count speed stage. Takes the 4-bit Delay and the 50-bit alive mask.
- Times and executes formation steps on frame ticks: horizontal march, edge-triggered descent with direction reversal, landing detection and wave-cleared detection.
- Outputs the formation origin (FormX, FormY) to the invader sprite/draw logic and the collision logic.

Parameters:
X_INIT, 64, formation origin X after reset/Restart
Y_INIT, 48, formation origin Y after reset/Restart
STEP_X, 8, pixels per horizontal step
STEP_Y, 16, pixels per descent
COL_PITCH, 32, X spacing between columns
ROW_PITCH, 24, Y spacing between rows
INV_W, 24, invader width
INV_H, 16, invader height
X_MIN, 16, left playfield limit
X_MAX, 624, right playfield limit
Y_LAND, 400, landing line
MIN_FRAMES, 1, frames per step added to Delay; legal range 1..16

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
FrameTick  in  1  one-cycle pulse per video frame
Start  in  1  one-cycle pulse; begins march from IDLE
Restart  in  1  one-cycle pulse; return to IDLE with init position
Pause  in  1  level; freezes frame counting and stepping
InvaderOn  in  50  alive mask; bit index = row*10 + col, row 0 at top
Delay  in  4  frames-per-step modifier, 0..15 (0 = no invaders)
FormX  out  10  formation origin X
FormY  out  10  formation origin Y
Dir  out  1  1 = moving right, 0 = moving left
StepPulse  out  1  high one cycle when a step is committed
Landed  out  1  level; formation has reached Y_LAND
Cleared  out  1  level; wave destroyed

Behaviour:
- Reset state (Reset_n=0, async): state IDLE, FormX=X_INIT, FormY=Y_INIT, Dir=1, StepPulse=0, Landed=0, Cleared=0, FrameCnt=0.
- States:
  - IDLE: hold outputs. Start → MARCH with FrameCnt=0.
  - MARCH: stepping and detection as below.
  - LANDED: Landed=1. Positions frozen, no StepPulse. Exit only via Restart or Reset_n.
  - CLEARED: Cleared=1. Positions frozen, no StepPulse. Exit only via Restart or Reset_n.
- Priority within a cycle: Restart > Cleared detect > Landed detect > step. Restart from any state gives exactly the reset values.
- Start outside IDLE is ignored.
- Combinational occupancy from InvaderOn:
  - Lc, Rc = leftmost and rightmost columns containing any alive bit.
  - Br = lowest row containing any alive bit.
- MARCH frame counting:
  - FrameCnt is 5 bits and advances only on FrameTick with Pause=0.
  - Period P = MIN_FRAMES + Delay, sampled live at each tick.
  - On a qualifying tick: if FrameCnt+1 >= P, a step is committed and FrameCnt←0; otherwise FrameCnt←FrameCnt+1.
  - If Delay drops so that FrameCnt already >= P, the step occurs at the next qualifying tick.
- Step commit (registered on the edge ending the tick cycle; StepPulse high the following cycle only):
  - Dir=1 and FormX + Rc*COL_PITCH + INV_W + STEP_X > X_MAX: descend.
  - Dir=0 and FormX + Lc*COL_PITCH < X_MIN + STEP_X: descend.
  - Descend: FormY += STEP_Y, Dir toggles, FormX unchanged.
  - Otherwise: FormX ± STEP_X per Dir.
- All edge/landing arithmetic uses 12-bit unsigned intermediates; no wrap.
- Cleared detect: in MARCH, any cycle with InvaderOn==0 → CLEARED on the next edge. Delay is not used for this detection.
- Landed detect: in MARCH, any cycle with FormY + Br*ROW_PITCH + INV_H >= Y_LAND and InvaderOn!=0 → LANDED on the next edge. A landing and a step in the same cycle: the step is suppressed.
- Pause=1: ticks are ignored. Detection still runs.

Test Plan:
1. Reset, then Start, all 50 alive, Delay=15, 32 ticks → StepPulse after tick 16 and tick 32; FormX 64→72→80; FormY=48.
2. All alive, Delay=0 forced, MIN_FRAMES=1, step every tick from FormX=64 → FormX reaches 312. The next step descends: FormY=64, Dir=0, FormX=312. The next step gives FormX=304.
3. Only column 0 alive (bits 0,10,20,30,40), Delay=5 → steps every 6 ticks. First descent occurs at FormX=600 (600+32 > 624).
4. All alive, FormY driven by descents to 288 → Landed=1 the next cycle. Further ticks give no StepPulse and FormX/FormY frozen.
5. InvaderOn→0 mid-count → Cleared=1 next cycle, no further steps. Restart → IDLE, FormX=64, FormY=48, Dir=1, Cleared=0.
6. Restart and FrameTick same cycle at the step boundary → no step, reset values. Reset_n low mid-MARCH → outputs to reset values without waiting for Clk. Pause=1 over 20 ticks → FormX unchanged, FrameCnt held.
